// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decoded fields and bypassed register-file
// operands for EX. Inserts a bubble on load-use hazards and on branch flush,
// and freezes under downstream hold. While frozen, operands that are being
// written back are refreshed so they are not stale when EX proceeds.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_data_rs1,
    input  logic [XLEN-1:0]   rf_data_rs2,
    input  logic              wb_write_enable,
    input  logic [4:0]        wb_addr_rd,
    input  logic [XLEN-1:0]   wb_data_rd,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              reg_write;
        logic              is_load;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    logic    load_use;

    // x0 reads as zero; a same-edge writeback beats the (old) register-file value.
    function automatic logic [XLEN-1:0] sel_operand(input logic [4:0]      addr,
                                                    input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] value;
        if (addr == 5'd0)
            value = '0;
        else if (wb_write_enable && (wb_addr_rd == addr))
            value = wb_data_rd;
        else
            value = rf_data;
        return value;
    endfunction

    // Hazard detection and stall from current EX state and ID inputs only.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        load_use = 1'b0;
        stall_id = 1'b0;
        if (ex_q.valid && ex_q.is_load && ex_q.reg_write &&
            (ex_q.rd_addr != 5'd0) && id_valid &&
            ((id_uses_rs1 && (id_rs1_addr == ex_q.rd_addr)) ||
             (id_uses_rs2 && (id_rs2_addr == ex_q.rd_addr))))
            load_use = 1'b1;

        if (rst)
            stall_id = 1'b0;
        else if (ex_hold)
            stall_id = 1'b1;
        else if (ex_flush)
            stall_id = 1'b0;
        else
            stall_id = load_use;
    end

    // Next EX contents: hold (with operand refresh), bubble, or load from ID.
    always_comb begin
        ex_d = ex_q;
        if (ex_hold) begin
            if ((ex_q.rs1_addr != 5'd0) && wb_write_enable && (wb_addr_rd == ex_q.rs1_addr))
                ex_d.rs1_data = wb_data_rd;
            if ((ex_q.rs2_addr != 5'd0) && wb_write_enable && (wb_addr_rd == ex_q.rs2_addr))
                ex_d.rs2_data = wb_data_rd;
        end else if (ex_flush || load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.reg_write = id_valid && id_reg_write;
            ex_d.is_load   = id_valid && id_is_load;
            ex_d.imm       = id_imm;
            ex_d.ctrl      = id_ctrl;
            ex_d.rs1_data  = sel_operand(id_rs1_addr, rf_data_rs1);
            ex_d.rs2_data  = sel_operand(id_rs2_addr, rf_data_rs2);
        end
    end

    // EX register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_addr  = ex_q.rs1_addr;
    assign ex_rs2_addr  = ex_q.rs2_addr;
    assign ex_rd_addr   = ex_q.rd_addr;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_imm       = ex_q.imm;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode/register-file read and execute.
- Captures the two register-file read operands and the decoded instruction fields.
- Applies a same-cycle writeback bypass, because the register file writes on the clock edge and reads combinationally.
- Detects load-use hazards and inserts bubbles; also handles branch flush and downstream hold.

Parameters:
XLEN, 32, datapath and PC width
CTRL_W, 16, width of opaque decoded control bundle passed to EX

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1_addr  input  5  source register 1 index (also drives register-file addr_rs1)
id_rs2_addr  input  5  source register 2 index
id_rd_addr  input  5  destination index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_reg_write  input  1  instruction writes rd
id_is_load  input  1  instruction is a load
id_imm  input  XLEN  decoded immediate
id_ctrl  input  CTRL_W  decoded control bundle
rf_data_rs1  input  XLEN  register-file read data for rs1
rf_data_rs2  input  XLEN  register-file read data for rs2
wb_write_enable  input  1  writeback write strobe (same signal as register-file write_enable)
wb_addr_rd  input  5  writeback destination
wb_data_rd  input  XLEN  writeback data
ex_flush  input  1  branch/jump resolved taken in EX; squash ID instruction
ex_hold  input  1  downstream not ready; freeze EX register
stall_id  output  1  combinational; IF/ID must hold its contents this cycle
ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_is_load, ex_imm, ex_ctrl  output  as ID  registered copies
ex_rs1_data  output  XLEN  registered operand 1
ex_rs2_data  output  XLEN  registered operand 2

Behaviour:
- Reset:
  - All ex_* outputs are 0, so ex_valid=0 and ex_reg_write=0.
  - stall_id=0 while rst=1.
- Operand select, combinational, computed per source:
  - If address==0: value is 0, regardless of rf_data.
  - Else if wb_write_enable and wb_addr_rd==address: value is wb_data_rd.
  - Else: value is rf_data.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_valid, ex_is_load and ex_reg_write;
  - ex_rd_addr!=0 and id_valid;
  - and either (id_uses_rs1 and id_rs1_addr==ex_rd_addr) or (id_uses_rs2 and id_rs2_addr==ex_rd_addr).
- Per-edge priority, first match wins:
  1. rst: clear, as above.
  2. ex_hold: all ex_* fields keep their values, except the operand refresh below. stall_id=1.
     - Operand refresh: for a held operand whose ex_rsN_addr!=0 and matches wb_addr_rd while wb_write_enable=1, ex_rsN_data is reloaded with wb_data_rd.
  3. ex_flush: load a bubble (ex_valid=0, ex_reg_write=0, ex_is_load=0; other fields don't-care but must be zeroed). stall_id=0.
  4. lu: load a bubble. stall_id=1. The ID instruction is re-presented next cycle and will then pass with no hazard.
  5. Otherwise: load all ID fields and the selected operands. ex_valid=id_valid. stall_id=0.
- Bubble propagation:
  - id_valid=0 loads ex_valid=0.
  - ex_reg_write and ex_is_load are forced to 0 whenever ex_valid is loaded as 0.
- Hold and flush together:
  - Hold wins over flush.
  - The flush source must keep ex_flush asserted until ex_hold drops; the flush is then applied on that first non-hold edge.
- stall_id timing: combinational from current EX state and ID inputs; it never depends on the next state.
- Latency: 1 cycle from ID to EX in the no-stall case. A load-use stall costs exactly 1 bubble.
- Hazards ignore the x0 destination: load to x0 never stalls.

Test Plan:
- Reset and normal pass:
  - Assert rst for 2 cycles, then check all ex_*=0 and stall_id=0.
  - Present id_valid=1, pc=0x100, rs1=3, rs2=4, rf data 0x33/0x44, no wb.
  - Next cycle: ex_pc=0x100, ex_rs1_data=0x33, ex_rs2_data=0x44, ex_valid=1.
- WB bypass and x0:
  - Inputs: rs1=5, rs2=0, rf_data_rs1=0x55, rf_data_rs2=0xDEAD, wb_write_enable=1, wb_addr_rd=5, wb_data_rd=0xABCD.
  - Required: ex_rs1_data=0xABCD, ex_rs2_data=0.
  - Also drive wb_addr_rd=0 with rs1=0: ex_rs1_data=0.
- Load-use stall:
  - EX holds a load with rd=7; ID has an add with uses_rs2=1, rs2=7.
  - Required: stall_id=1 that cycle and ex_valid=0 next cycle.
  - The following cycle the add enters EX with ex_valid=1 and stall_id=0.
  - Repeat with rd=0: no stall.
- Flush beats load-use:
  - Set up the load-use condition above and assert ex_flush=1.
  - Required: stall_id=0 and next-cycle ex_valid=0, ex_reg_write=0.
- Hold with refresh:
  - EX holds an instr with ex_rs1_addr=9 and data 0x11.
  - Assert ex_hold for 3 cycles; on cycle 2 drive wb_write_enable=1, wb_addr_rd=9, wb_data_rd=0x99.
  - Required: stall_id=1 throughout and ex_rs1_data=0x99 after cycle 2; all other fields unchanged.
- Reset mid-stall:
  - With the load-use condition active, assert rst for 1 cycle.
  - Required: ex_valid=0 and stall_id=0 during reset; the next ID instruction passes normally.
